// File: rtl/mem_mock_slave.sv
// Memory-bus responder with backing store, valid bitmap, error and transfer count. Optional MEM_MOCK_STALL_EN adds LFSR stalls.
// Latency: ack is registered LATENCY edges after req capture. With stalls it may come later.
// Backpressure: one transaction at a time. req/we/addr/wdata are ignored outside IDLE.
module mem_mock_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter int                    LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic [15:0]           xfer_cnt
);
    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [15:0]           r_xfer_cnt;

    logic                  w_stall;
    logic                  w_cap;
    logic                  w_cap_ok;
    logic [IDX_W-1:0]      w_cap_idx;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_ok;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [DATA_WIDTH-1:0] w_resp;
    logic                  w_go_ack;

    assign w_cap     = (r_state == IDLE) && req;
    assign w_cap_ok  = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_cap_idx = addr[IDX_W-1:0];

    // With zero latency the response is built from the live bus, otherwise from the captured copy.
    assign w_sel_we   = (r_state == IDLE) ? we   : r_we;
    assign w_sel_addr = (r_state == IDLE) ? addr : r_addr;
    assign w_sel_ok   = ({1'b0, w_sel_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_sel_idx  = w_sel_addr[IDX_W-1:0];

    always_comb begin
        w_resp = '0;
        if (w_sel_ok && !w_sel_we) begin
            if (r_valid[w_sel_idx])
                w_resp = r_mem[w_sel_idx];
            else
                w_resp = DATA_WIDTH'(w_sel_addr) ^ SEED;
        end
    end

    assign w_go_ack = !w_stall &&
                      ((w_cap && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0)));

`ifdef MEM_MOCK_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, shifting right.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // The store itself is never reset; only the valid bitmap is.
    always_ff @(posedge clk) begin
        if (reset_n && w_cap && we && w_cap_ok)
            r_mem[w_cap_idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_valid    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            if (w_go_ack) begin
                r_ack      <= 1'b1;
                r_err      <= !w_sel_ok;
                r_rdata    <= w_resp;
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we   <= we;
                        r_addr <= addr;
                        if (we && w_cap_ok)
                            r_valid[w_cap_idx] <= 1'b1;
                        if (w_go_ack) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else if (w_go_ack)
                        r_state <= ACK;
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign xfer_cnt = r_xfer_cnt;
endmodule

// File: tb/tb_mem_mock_slave.sv
module tb_mem_mock_slave;
`ifdef MEM_MOCK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req      [3];
    logic        we       [3];
    logic [7:0]  addr     [3];
    logic [31:0] wdata    [3];
    logic        ack      [3];
    logic [31:0] rdata    [3];
    logic        err      [3];
    logic [15:0] xfer_cnt [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_mock_slave #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .xfer_cnt(xfer_cnt[0]));

    mem_mock_slave #(.LATENCY(3), .SEED(32'hA5A5A5A5)) u_l3 (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .xfer_cnt(xfer_cnt[1]));

    mem_mock_slave #(.DEPTH(128), .LATENCY(1)) u_d128 (
        .clk(clk), .reset_n(reset_n), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .xfer_cnt(xfer_cnt[2]));

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Drives one transaction; lat = cycles from capture edge to the ack cycle (L+1), -1 on timeout.
    task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        n = 0;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        while (ack[d] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        lat = (ack[d] === 1'b1) ? n + 1 : -1;
        rd  = rdata[d];
        e   = err[d];
        req[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0 || xfer_cnt[d] !== 16'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ack=%b err=%b rdata=%h cnt=%h, required all zero",
                         d, ack[d], err[d], rdata[d], xfer_cnt[d]);
            end
        end
    endtask

    task automatic test_latency0();
        logic [31:0] rd; logic e; int lat;
        do_reset();
        xfer(0, 1'b1, 8'd5, 32'hDEADBEEF, rd, e, lat);
        checks++;
        if (STALL ? (lat < 1) : (lat !== 1)) begin
            errors++; $display("FAIL l0_write_lat: got %0d required 1", lat);
        end
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL l0_write_resp: rdata=%h err=%b required 0/0", rd, e);
        end
        checks++;
        if (rdata[0] !== 32'h0) begin
            errors++; $display("FAIL l0_rdata_after_ack: got %h required 0", rdata[0]);
        end
        xfer(0, 1'b0, 8'd5, 32'h0, rd, e, lat);
        checks++;
        if (STALL ? (lat < 1) : (lat !== 1)) begin
            errors++; $display("FAIL l0_read_lat: got %0d required 1", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL l0_read_data: rdata=%h err=%b required deadbeef/0", rd, e);
        end
        checks++;
        if (xfer_cnt[0] !== 16'd2) begin
            errors++; $display("FAIL l0_xfer_cnt: got %0d required 2", xfer_cnt[0]);
        end
    endtask

    task automatic test_seed_latency();
        logic [31:0] rd; logic e; int lat;
        do_reset();
        xfer(1, 1'b0, 8'h10, 32'h0, rd, e, lat);
        checks++;
        if (STALL ? (lat < 4) : (lat !== 4)) begin
            errors++; $display("FAIL l3_read_lat: got %0d required 4", lat);
        end
        checks++;
        if (rd !== 32'hA5A5A5B5 || e !== 1'b0) begin
            errors++; $display("FAIL l3_pattern: rdata=%h err=%b required a5a5a5b5/0", rd, e);
        end
        xfer(1, 1'b1, 8'h10, 32'h0BADF00D, rd, e, lat);
        xfer(1, 1'b0, 8'h10, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++; $display("FAIL l3_readback: got %h required 0badf00d", rd);
        end
        checks++;
        if (xfer_cnt[1] !== 16'd3) begin
            errors++; $display("FAIL l3_xfer_cnt: got %0d required 3", xfer_cnt[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat;
        do_reset();
        xfer(2, 1'b1, 8'd200, 32'h00001234, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL oor_write: err=%b rdata=%h required 1/0", e, rd);
        end
        xfer(2, 1'b0, 8'd200, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL oor_read: err=%b rdata=%h required 1/0", e, rd);
        end
        xfer(2, 1'b0, 8'd72, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h00000048) begin
            errors++; $display("FAIL oor_alias72: err=%b rdata=%h required 0/00000048", e, rd);
        end
        xfer(2, 1'b1, 8'd127, 32'hCAFEF00D, rd, e, lat);
        xfer(2, 1'b0, 8'd127, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL top_word: err=%b rdata=%h required 0/cafef00d", e, rd);
        end
        xfer(2, 1'b0, 8'd128, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL first_oor: err=%b rdata=%h required 1/0", e, rd);
        end
        checks++;
        if (xfer_cnt[2] !== 16'd6) begin
            errors++; $display("FAIL oor_xfer_cnt: got %0d required 6", xfer_cnt[2]);
        end
    endtask

    task automatic test_back_to_back();
        int acks, doubles;
        logic prev;
        do_reset();
        acks = 0; doubles = 0; prev = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack[0] === 1'b1) acks++;
            if (ack[0] === 1'b1 && prev) doubles++;
            prev = ack[0];
        end
        req[0] = 1'b0;
        checks++;
        if (STALL ? (acks < 1 || acks > 10) : (acks !== 10)) begin
            errors++; $display("FAIL b2b_acks: got %0d required 10", acks);
        end
        checks++;
        if (doubles !== 0) begin
            errors++; $display("FAIL b2b_double_ack: got %0d required 0", doubles);
        end
        checks++;
        if (xfer_cnt[0] !== (STALL ? 16'(acks) : 16'd10)) begin
            errors++; $display("FAIL b2b_xfer_cnt: got %0d required 10", xfer_cnt[0]);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic e; int lat, acks;
        do_reset();
        acks = 0;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'd3; wdata[1] = 32'h00000077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        req[1] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ack[1] === 1'b1) acks++;
            @(posedge clk); #1;
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL rst_wait_ack: got %0d acks required 0", acks);
        end
        checks++;
        if (xfer_cnt[1] !== 16'd0) begin
            errors++; $display("FAIL rst_wait_cnt: got %0d required 0", xfer_cnt[1]);
        end
        xfer(1, 1'b0, 8'd3, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hA5A5A5A6 || e !== 1'b0) begin
            errors++; $display("FAIL rst_wait_valid: rdata=%h err=%b required a5a5a5a6/0", rd, e);
        end
    endtask

    task automatic test_latency_seq();
        logic [31:0] rd; logic e;
        int lat1 [50];
        int lat2 [50];
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int i = 0; i < 50; i++) begin
                int lat;
                xfer(2, 1'b0, 8'(i), 32'h0, rd, e, lat);
                if (run == 0) lat1[i] = lat; else lat2[i] = lat;
                checks++;
                if (STALL ? (lat < 2) : (lat !== 2)) begin
                    errors++; $display("FAIL seq_lat run%0d idx%0d: got %0d required 2", run, i, lat);
                end
                checks++;
                if (rd !== 32'(i) || e !== 1'b0) begin
                    errors++; $display("FAIL seq_data run%0d idx%0d: rdata=%h err=%b required %h/0",
                                       run, i, rd, e, 32'(i));
                end
            end
        end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (lat2[i] !== lat1[i]) begin
                errors++; $display("FAIL seq_repeat idx%0d: run2 %0d run1 %0d", i, lat2[i], lat1[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency0();
        test_seed_latency();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
        test_latency_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
